cl_pixel_stream_fmt: RTL and testbench

// Parametrised CameraLink pixel formatter. Takes deserialised tap data and LVAL/FVAL/DVAL per channel, already retimed to sys_clk.

---
 rtl/cl_pixel_stream_fmt.sv | 210 +++++++++++++++++++++
 tb/tb_cl_pixel_stream_fmt.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_pixel_stream_fmt.sv
`default_nettype none
// ============================================================================
// Module : cl_pixel_stream_fmt
// Brief  : CameraLink tap/LVAL/FVAL/DVAL formatter to AXI4-Stream with a
//          one-beat hold stage, FWFT output FIFO and frame statistics.
// Rev    : 1.0  initial release
// ============================================================================
module cl_pixel_stream_fmt #(
    parameter int NUM_TAPS   = 3,
    parameter int TAP_W      = 8,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int USE_DVAL   = 1
) (
    input  logic                          sys_clk,
    input  logic                          ap_rst_n,
    input  logic                          en,
    input  logic                          cfg_line_scan,
    input  logic [CNT_W-1:0]              cfg_lines_per_frame,
    input  logic                          clr_status,
    input  logic                          s_valid,
    input  logic [3:0]                    s_lfds,
    input  logic [NUM_TAPS*TAP_W-1:0]     s_data,
    output logic [NUM_TAPS*TAP_W-1:0]     m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tuser,
    output logic                          m_tlast,
    output logic [CNT_W-1:0]              pix_cnt,
    output logic [CNT_W-1:0]              line_cnt,
    output logic [CNT_W-1:0]              last_width,
    output logic [CNT_W-1:0]              last_height,
    output logic [15:0]                   frame_cnt,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int         c_DATA_W   = NUM_TAPS * TAP_W;
    localparam int         c_AW       = $clog2(FIFO_DEPTH);
    localparam logic       c_USE_DVAL = (USE_DVAL != 0);
    localparam logic [1:0] c_ST_SYNC  = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_FRAME = 2'd2;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]          r_state, w_state_nxt;
    logic                r_hold_vld, w_hold_vld_nxt;
    logic                r_hold_user, w_hold_user_nxt;
    logic [c_DATA_W-1:0] r_hold_data, w_hold_data_nxt;
    logic                r_sof_pend, w_sof_nxt;
    logic [CNT_W-1:0]    r_pix_cnt, w_pix_nxt;
    logic [CNT_W-1:0]    r_line_cnt, w_line_nxt;
    logic [CNT_W-1:0]    r_last_width, w_width_nxt;
    logic [CNT_W-1:0]    r_last_height, w_height_nxt;
    logic [15:0]         r_frame_cnt, w_frames_nxt;
    logic                r_ovf, w_ovf_nxt;

    logic [c_DATA_W+1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]       r_level;

    logic w_lval, w_fval, w_dval, w_unused;
    logic w_q, w_in_frame, w_beat, w_line_end, w_area_eof, w_line_eof;
    logic w_push, w_pop, w_full, w_drop, w_wr;
    logic [CNT_W-1:0] w_lpf, w_line_inc;

    assign w_lval   = s_lfds[3];
    assign w_fval   = s_lfds[2];
    assign w_dval   = s_lfds[1];
    assign w_unused = s_lfds[0];

    assign w_q        = s_valid & w_lval & (w_fval | cfg_line_scan) & (w_dval | ~c_USE_DVAL);
    assign w_in_frame = en & (r_state == c_ST_FRAME);
    assign w_lpf      = (cfg_lines_per_frame == '0) ? CNT_W'(1) : cfg_lines_per_frame;
    assign w_line_inc = f_sat_inc(r_line_cnt);

    // The hold stage being occupied is exactly "a line is open".
    assign w_beat     = w_in_frame & w_q;
    assign w_area_eof = w_in_frame & ~cfg_line_scan & s_valid & ~w_fval;
    assign w_line_end = w_in_frame & s_valid & r_hold_vld & (~w_lval | (~w_fval & ~cfg_line_scan));
    assign w_line_eof = w_line_end & cfg_line_scan & (w_line_inc == w_lpf);

    assign w_push = (w_beat | w_line_end) & r_hold_vld;
    assign w_pop  = (r_level != '0) & m_tready;
    assign w_full = (r_level == (c_AW+1)'(FIFO_DEPTH));
    assign w_drop = w_push & w_full & ~w_pop;
    assign w_wr   = w_push & ~w_drop;

    always_ff @(posedge sys_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= c_ST_SYNC;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_SYNC:  if (s_valid && (cfg_line_scan ? !w_lval : !w_fval)) w_state_nxt = c_ST_IDLE;
            c_ST_IDLE:  if (cfg_line_scan || (s_valid && w_fval)) w_state_nxt = c_ST_FRAME;
            c_ST_FRAME: if (w_area_eof) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_SYNC;
        endcase
        if (!en || w_drop) w_state_nxt = c_ST_SYNC;
    end

    always_comb begin
        w_hold_vld_nxt  = r_hold_vld;
        w_hold_user_nxt = r_hold_user;
        w_hold_data_nxt = r_hold_data;
        w_sof_nxt       = r_sof_pend;
        w_pix_nxt       = r_pix_cnt;
        w_line_nxt      = r_line_cnt;
        w_width_nxt     = r_last_width;
        w_height_nxt    = r_last_height;
        w_frames_nxt    = r_frame_cnt;
        w_ovf_nxt       = clr_status ? 1'b0 : r_ovf;
        if (!en || w_drop) begin
            // Abandoned line: nothing partial survives, output resumes at a clean frame.
            w_hold_vld_nxt = 1'b0;
            w_pix_nxt      = '0;
            if (w_drop) w_ovf_nxt = 1'b1;
        end else begin
            if (r_state != c_ST_FRAME && w_state_nxt == c_ST_FRAME) w_sof_nxt = 1'b1;
            if (w_beat) begin
                w_hold_vld_nxt  = 1'b1;
                w_hold_data_nxt = s_data;
                w_hold_user_nxt = r_sof_pend;
                w_sof_nxt       = 1'b0;
                w_pix_nxt       = f_sat_inc(r_pix_cnt);
                if (r_sof_pend) w_line_nxt = '0;
            end else if (w_line_end) begin
                w_hold_vld_nxt = 1'b0;
                w_width_nxt    = r_pix_cnt;
                w_pix_nxt      = '0;
                w_line_nxt     = w_line_inc;
                if (w_line_eof) begin
                    w_height_nxt = w_line_inc;
                    w_frames_nxt = r_frame_cnt + 16'd1;
                    w_sof_nxt    = 1'b1;
                end
            end
            if (w_area_eof) begin
                w_height_nxt = w_line_end ? w_line_inc : r_line_cnt;
                w_frames_nxt = r_frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_hold_vld    <= 1'b0;
            r_hold_user   <= 1'b0;
            r_hold_data   <= '0;
            r_sof_pend    <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_cnt    <= '0;
            r_last_width  <= '0;
            r_last_height <= '0;
            r_frame_cnt   <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_hold_vld    <= w_hold_vld_nxt;
            r_hold_user   <= w_hold_user_nxt;
            r_hold_data   <= w_hold_data_nxt;
            r_sof_pend    <= w_sof_nxt;
            r_pix_cnt     <= w_pix_nxt;
            r_line_cnt    <= w_line_nxt;
            r_last_width  <= w_width_nxt;
            r_last_height <= w_height_nxt;
            r_frame_cnt   <= w_frames_nxt;
            r_ovf         <= w_ovf_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_hold_user, w_line_end, r_hold_data};
    end

    always_ff @(posedge sys_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign m_tvalid    = (r_level != '0);
    assign m_tdata     = m_tvalid ? r_mem[r_rd_ptr][c_DATA_W-1:0] : '0;
    assign m_tlast     = m_tvalid & r_mem[r_rd_ptr][c_DATA_W];
    assign m_tuser     = m_tvalid & r_mem[r_rd_ptr][c_DATA_W+1];
    assign pix_cnt     = r_pix_cnt;
    assign line_cnt    = r_line_cnt;
    assign last_width  = r_last_width;
    assign last_height = r_last_height;
    assign frame_cnt   = r_frame_cnt;
    assign ovf         = r_ovf;
    assign fifo_level  = r_level;

endmodule
`default_nettype wire

// File: tb/tb_cl_pixel_stream_fmt.sv
`default_nettype none
// ============================================================================
// Module : tb_cl_pixel_stream_fmt
// Brief  : Self-checking bench; expected streams are built from frame shapes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cl_pixel_stream_fmt;

    localparam int DW = 24;

    logic          sys_clk = 1'b0;
    logic          ap_rst_n;
    logic          en, cfg_line_scan, clr_status, s_valid, m_tready;
    logic [15:0]   cfg_lines_per_frame;
    logic [3:0]    s_lfds;
    logic [DW-1:0] s_data, m_tdata;
    logic          m_tvalid, m_tuser, m_tlast, ovf;
    logic [15:0]   pix_cnt, line_cnt, last_width, last_height, frame_cnt;
    logic [4:0]    fifo_level;

    cl_pixel_stream_fmt dut (
        .sys_clk(sys_clk), .ap_rst_n(ap_rst_n), .en(en), .cfg_line_scan(cfg_line_scan),
        .cfg_lines_per_frame(cfg_lines_per_frame), .clr_status(clr_status),
        .s_valid(s_valid), .s_lfds(s_lfds), .s_data(s_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .pix_cnt(pix_cnt), .line_cnt(line_cnt),
        .last_width(last_width), .last_height(last_height), .frame_cnt(frame_cnt),
        .ovf(ovf), .fifo_level(fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int nl; int nb; bit gaps;
        int exp_beats; int exp_w; int exp_h;
    } vec_t;

    int          checks = 0, errors = 0, exp_frames = 0;
    bit          rand_ready = 0, tready_fix = 1, track = 0;
    int          peak = 0;
    logic [25:0] rx[$], exp_q[$];

    // Output monitor: a beat transfers at the edge following a negedge with valid&ready.
    always @(negedge sys_clk) begin
        if (ap_rst_n && m_tvalid && m_tready) rx.push_back({m_tuser, m_tlast, m_tdata});
        if (track && int'(pix_cnt) > peak) peak = int'(pix_cnt);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic step(input bit v, input bit l, input bit f, input bit d, input logic [DW-1:0] dat);
        s_valid  = v;
        s_lfds   = {l, f, d, 1'b0};
        s_data   = dat;
        m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : tready_fix;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_line(input int nb, input bit sof, input bit rec, input bit gaps,
                             input bit alt, input bit fv);
        logic [DW-1:0] d;
        for (int j = 0; j < nb; j++) begin
            if (gaps) begin
                case ($urandom_range(0, 2))
                    0: step(0, 1, fv, 1, DW'($urandom));
                    1: step(1, 1, fv, 0, DW'($urandom));
                    default: ;
                endcase
            end
            d = DW'($urandom);
            step(1, 1, fv, 1, d);
            if (rec) exp_q.push_back({sof && (j == 0), j == nb - 1, d});
            if (alt) step(1, 1, fv, 0, DW'($urandom));
        end
        step(1, 0, fv, 0, DW'($urandom));
    endtask

    task automatic send_area_frame(input int nl, input int nb, input bit gaps, input bit alt);
        step(1, 0, 0, 0, DW'($urandom));
        step(1, 0, 0, 0, DW'($urandom));
        step(1, 0, 1, 0, DW'($urandom));
        step(1, 0, 1, 0, DW'($urandom));
        for (int i = 0; i < nl; i++) send_line(nb, i == 0, 1, gaps, alt, 1);
        step(1, 0, 0, 0, DW'($urandom));
        exp_frames++;
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_level != 0 && n < 400) begin
            step(0, 0, 0, 0, '0);
            n++;
        end
        chk("drain_done", 32'(fifo_level), 32'd0);
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_count"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), 32'(rx[i]), 32'(exp_q[i]));
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t          tbl[4];
        logic [DW-1:0] d;
        int            nl, nb;

        tbl[0] = '{4, 5, 1'b0, 20, 5, 4};
        tbl[1] = '{1, 1, 1'b0, 1, 1, 1};
        tbl[2] = '{2, 7, 1'b1, 14, 7, 2};
        tbl[3] = '{3, 2, 1'b1, 6, 2, 3};

        ap_rst_n = 0; en = 0; cfg_line_scan = 0; cfg_lines_per_frame = 16'd0;
        clr_status = 0; s_valid = 0; s_lfds = '0; s_data = '0; m_tready = 1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_counters", 32'(pix_cnt | line_cnt | last_width | last_height), 0);
        ap_rst_n = 1;
        en = 1;

        // Area frames of fixed shapes, ready always high.
        for (int k = 0; k < 4; k++) begin
            send_area_frame(tbl[k].nl, tbl[k].nb, tbl[k].gaps, 0);
            drain();
            chk("tbl_beats", rx.size(), tbl[k].exp_beats);
            cmp_stream("tbl_stream");
            chk("tbl_last_width", 32'(last_width), tbl[k].exp_w);
            chk("tbl_last_height", 32'(last_height), tbl[k].exp_h);
            chk("tbl_line_cnt", 32'(line_cnt), tbl[k].exp_h);
            chk("tbl_pix_cnt", 32'(pix_cnt), 0);
            chk("tbl_frame_cnt", 32'(frame_cnt), exp_frames);
        end

        // Enable rises mid-frame: that frame is suppressed entirely.
        en = 0;
        step(1, 0, 0, 0, DW'($urandom));
        step(1, 0, 1, 0, DW'($urandom));
        send_line(4, 1, 0, 0, 0, 1);
        en = 1;
        send_line(4, 0, 0, 0, 0, 1);
        send_line(4, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, DW'($urandom));
        chk("midframe_level", 32'(fifo_level), 0);
        send_area_frame(2, 3, 0, 0);
        drain();
        cmp_stream("midframe_next");
        chk("midframe_frame_cnt", 32'(frame_cnt), exp_frames);

        // Random shapes, random gaps and backpressure.
        rand_ready = 1;
        for (int r = 0; r < 6; r++) begin
            nl = $urandom_range(1, 3);
            nb = $urandom_range(1, 4);
            send_area_frame(nl, nb, 1, 0);
            drain();
            cmp_stream("rand_stream");
            chk("rand_last_width", 32'(last_width), nb);
            chk("rand_last_height", 32'(last_height), nl);
            chk("rand_frame_cnt", 32'(frame_cnt), exp_frames);
        end
        rand_ready = 0;

        // Overflow: 3x8 frame with no ready; the 17th push is dropped.
        tready_fix = 0;
        send_area_frame(3, 8, 0, 0);
        exp_frames--;
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_level", 32'(fifo_level), 16);
        tready_fix = 1;
        drain();
        cmp_stream("ovf_drain");
        send_area_frame(2, 3, 0, 0);
        drain();
        cmp_stream("ovf_next");
        chk("ovf_frame_cnt", 32'(frame_cnt), exp_frames);
        chk("ovf_sticky", 32'(ovf), 1);
        clr_status = 1;
        step(0, 0, 0, 0, '0);
        clr_status = 0;
        chk("ovf_cleared", 32'(ovf), 0);

        // Push into a full FIFO with a simultaneous pop.
        tready_fix = 0;
        send_area_frame(2, 8, 0, 0);
        chk("full_level", 32'(fifo_level), 16);
        step(1, 0, 0, 0, DW'($urandom));
        step(1, 0, 0, 0, DW'($urandom));
        step(1, 0, 1, 0, DW'($urandom));
        step(1, 0, 1, 0, DW'($urandom));
        d = DW'($urandom);
        step(1, 1, 1, 1, d);
        exp_q.push_back({1'b1, 1'b0, d});
        tready_fix = 1;
        d = DW'($urandom);
        step(1, 1, 1, 1, d);
        exp_q.push_back({1'b0, 1'b0, d});
        chk("full_pushpop_level", 32'(fifo_level), 16);
        chk("full_pushpop_ovf", 32'(ovf), 0);
        d = DW'($urandom);
        step(1, 1, 1, 1, d);
        exp_q.push_back({1'b0, 1'b1, d});
        step(1, 0, 1, 0, DW'($urandom));
        step(1, 0, 0, 0, DW'($urandom));
        exp_frames++;
        drain();
        cmp_stream("full_stream");

        // Line-scan, 3 lines per frame, 7 lines.
        en = 0;
        step(0, 0, 0, 0, '0);
        cfg_line_scan = 1;
        cfg_lines_per_frame = 16'd3;
        en = 1;
        step(1, 0, 0, 0, DW'($urandom));
        step(0, 0, 0, 0, '0);
        for (int i = 0; i < 7; i++) begin
            send_line(2, (i % 3) == 0, 1, 0, 0, 0);
            if (i == 5) begin
                exp_frames += 2;
                chk("ls_frame_cnt_line6", 32'(frame_cnt), exp_frames);
            end
        end
        drain();
        cmp_stream("ls_stream");
        chk("ls_last_height", 32'(last_height), 3);
        chk("ls_line_cnt", 32'(line_cnt), 1);
        en = 0;
        step(0, 0, 0, 0, '0);
        cfg_line_scan = 0;
        en = 1;

        // DVAL low on alternate strobes: 10 strobes -> 5 beats per line.
        peak = 0;
        track = 1;
        send_area_frame(2, 5, 0, 1);
        track = 0;
        drain();
        cmp_stream("dval_stream");
        chk("dval_pix_peak", peak, 5);
        chk("dval_last_width", 32'(last_width), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
